// File: rtl/servo_pkg.sv
// servo_pkg: shared types, default constants and width helpers for the
// servo PWM driver.
//   width_t       16-bit unsigned pulse width in microseconds
//   servo_state_t drive state {IDLE, RUN, FAILSAFE}
//   calc_width()  command -> clamped pulse width
//   slew_step()   saturating move of a width toward a target
package servo_pkg;

    typedef logic [15:0] width_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        FAILSAFE = 2'd2
    } servo_state_t;

    localparam int CENTER_US_DEF = 1500;
    localparam int MIN_US_DEF    = 1000;
    localparam int MAX_US_DEF    = 2000;

    // Command is already sign-extended to 16 bits; the math is done in int so
    // negating -128 (or any extreme) cannot overflow.
    function automatic width_t calc_width(input logic signed [15:0] cmd,
                                          input logic inv,
                                          input int center,
                                          input int step,
                                          input int min_us,
                                          input int max_us);
        int c;
        int t;
        c = int'(cmd);
        t = inv ? (center - c * step) : (center + c * step);
        if (t < min_us) t = min_us;
        if (t > max_us) t = max_us;
        return width_t'(t);
    endfunction

    function automatic width_t slew_step(input width_t cur,
                                         input width_t tgt,
                                         input int step);
        int d;
        d = int'(tgt) - int'(cur);
        if (d > step)       return width_t'(int'(cur) + step);
        else if (d < -step) return width_t'(int'(cur) - step);
        else                return tgt;
    endfunction

endpackage

// File: rtl/servo_pwm_driver_if.sv
// servo_pwm_driver_if: wheel-command handshake between the command source
// (master) and the servo driver (slave).
//   wheel_left/right  signed wheel commands
//   cmd_valid         command pair valid
//   cmd_ready         driver can accept a command
interface servo_pwm_driver_if #(
    parameter int WIDTH_CMD = 8
) ();
    logic signed [WIDTH_CMD-1:0] wheel_left;
    logic signed [WIDTH_CMD-1:0] wheel_right;
    logic                        cmd_valid;
    logic                        cmd_ready;

    modport master (
        output wheel_left, wheel_right, cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  wheel_left, wheel_right, cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/servo_us_timebase.sv
// servo_us_timebase: microsecond prescaler and frame counter shared by both
// servo channels.
//   clk, reset   clock, async active-high reset
//   us_cnt       microsecond position within the frame, 0..FRAME_US-1
//   frame_start  one-cycle pulse in the cycle us_cnt becomes 0
// The first frame starts on the first microsecond tick after reset rather
// than after a full frame, so the outputs come alive quickly.
module servo_us_timebase
    import servo_pkg::*;
#(
    parameter int CLKS_PER_US = 100,
    parameter int FRAME_US    = 20000
) (
    input  logic   clk,
    input  logic   reset,
    output width_t us_cnt,
    output logic   frame_start
);
    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    logic [PW-1:0] pre;
    logic          started;
    logic          us_tick;

    assign us_tick = (pre == PW'(CLKS_PER_US - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre         <= '0;
            us_cnt      <= '0;
            started     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (us_tick) begin
                pre <= '0;
                if (!started || us_cnt == width_t'(FRAME_US - 1)) begin
                    us_cnt      <= '0;
                    frame_start <= 1'b1;
                    started     <= 1'b1;
                end else begin
                    us_cnt <= us_cnt + 16'd1;
                end
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end
endmodule

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: turns signed left/right wheel commands into 50 Hz servo
// pulse-width signals for two continuous-rotation drive servos.
//   clk, reset    clock, async active-high reset
//   enable        drive enable, sampled at frame start
//   cif           command handshake (wheel_left/right, cmd_valid, cmd_ready)
//   servo_left    left PWM output
//   servo_right   right PWM output
//   frame_start   one-cycle pulse at the first clk of each frame
//   failsafe      high while the watchdog holds the outputs at neutral
// Optional: define SERVO_SLEW_LIMIT_EN to limit the per-frame width change
// to SLEW_US.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int WIDTH_CMD       = 8,
    parameter int CLKS_PER_US     = 100,
    parameter int FRAME_US        = 20000,
    parameter int CENTER_US       = CENTER_US_DEF,
    parameter int US_PER_STEP     = 4,
    parameter int MIN_US          = MIN_US_DEF,
    parameter int MAX_US          = MAX_US_DEF,
    parameter bit INVERT_RIGHT    = 1'b1,
`ifdef SERVO_SLEW_LIMIT_EN
    parameter int SLEW_US         = 20,
`endif
    parameter int WATCHDOG_FRAMES = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    servo_pwm_driver_if.slave   cif,
    output logic                servo_left,
    output logic                servo_right,
    output logic                frame_start,
    output logic                failsafe
);
    localparam int WDW = $clog2(WATCHDOG_FRAMES + 1);

    width_t       us_cnt;
    servo_state_t state, state_n;
    logic [WDW-1:0] wd, wd_inc;
    logic         rdy_q;
    logic         pending;
    logic         acc;
    logic         cmd_seen;
    logic         pulse_en_n;
    width_t       shadow_l, shadow_r;
    width_t       act_l, act_r, act_l_n, act_r_n;
    width_t       tgt_l_in, tgt_r_in;
    width_t       eff_l, eff_r;

    servo_us_timebase #(
        .CLKS_PER_US (CLKS_PER_US),
        .FRAME_US    (FRAME_US)
    ) u_tb (
        .clk         (clk),
        .reset       (reset),
        .us_cnt      (us_cnt),
        .frame_start (frame_start)
    );

    assign cif.cmd_ready = rdy_q;
    assign acc           = cif.cmd_valid && rdy_q;
    // A command accepted during the frame, or on the frame_start cycle itself.
    assign cmd_seen      = pending || acc;
    assign wd_inc        = wd + WDW'(1);

    assign tgt_l_in = calc_width(16'($signed(cif.wheel_left)), 1'b0,
                                 CENTER_US, US_PER_STEP, MIN_US, MAX_US);
    assign tgt_r_in = calc_width(16'($signed(cif.wheel_right)), INVERT_RIGHT,
                                 CENTER_US, US_PER_STEP, MIN_US, MAX_US);

    // Same-cycle accept bypasses the shadow so it lands in this frame.
    assign eff_l = acc ? tgt_l_in : shadow_l;
    assign eff_r = acc ? tgt_r_in : shadow_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q    <= 1'b0;
            pending  <= 1'b0;
            shadow_l <= width_t'(CENTER_US);
            shadow_r <= width_t'(CENTER_US);
        end else begin
            rdy_q <= 1'b1;
            if (acc) begin
                shadow_l <= tgt_l_in;
                shadow_r <= tgt_r_in;
            end
            if (frame_start)  pending <= 1'b0;
            else if (acc)     pending <= 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // FSM: next state, evaluated only at frame boundaries
    always_comb begin
        state_n = state;
        if (frame_start) begin
            if (!enable) begin
                state_n = IDLE;
            end else begin
                case (state)
                    IDLE:     state_n = RUN;
                    RUN:      if (!cmd_seen && wd_inc == WDW'(WATCHDOG_FRAMES))
                                  state_n = FAILSAFE;
                    FAILSAFE: if (cmd_seen) state_n = RUN;
                    default:  state_n = IDLE;
                endcase
            end
        end
    end

    // FSM: outputs. pulse_en_n looks ahead so the pulse can rise right after
    // frame_start with the new frame's enable.
    always_comb begin
        failsafe   = (state == FAILSAFE);
        pulse_en_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd <= '0;
        end else if (frame_start) begin
            if (!enable || state == IDLE || cmd_seen) wd <= '0;
            else if (state == RUN)                    wd <= wd_inc;
        end
    end

    always_comb begin
        act_l_n = act_l;
        act_r_n = act_r;
        if (frame_start) begin
            if (state_n == FAILSAFE) begin
                act_l_n = width_t'(CENTER_US);
                act_r_n = width_t'(CENTER_US);
            end else begin
`ifdef SERVO_SLEW_LIMIT_EN
                act_l_n = slew_step(act_l, eff_l, SLEW_US);
                act_r_n = slew_step(act_r, eff_r, SLEW_US);
`else
                act_l_n = eff_l;
                act_r_n = eff_r;
`endif
            end
        end
    end

    // Outputs are registered from the next-cycle widths so the pulse starts
    // one cycle after frame_start and never glitches mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_l       <= width_t'(CENTER_US);
            act_r       <= width_t'(CENTER_US);
            servo_left  <= 1'b0;
            servo_right <= 1'b0;
        end else begin
            act_l       <= act_l_n;
            act_r       <= act_r_n;
            servo_left  <= pulse_en_n && (us_cnt < act_l_n);
            servo_right <= pulse_en_n && (us_cnt < act_r_n);
        end
    end
endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: scoreboard bench for servo_pwm_driver, run with a
// shortened frame (2 clk/us, 2100 us frame, 3-frame watchdog).
module tb_servo_pwm_driver;
    localparam int CLKS  = 2;
    localparam int FRAME = 2100;
    localparam int WDOG  = 3;

    typedef struct {
        int l_us;
        int r_us;
        int fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic servo_left, servo_right, frame_start, failsafe;

    int n_pass = 0;
    int n_total = 0;
    exp_t sb[$];
    bit mon_en = 1'b1;

    servo_pwm_driver_if #(.WIDTH_CMD(8)) cif ();

    servo_pwm_driver #(
        .WIDTH_CMD       (8),
        .CLKS_PER_US     (CLKS),
        .FRAME_US        (FRAME),
        .WATCHDOG_FRAMES (WDOG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cif         (cif.slave),
        .servo_left  (servo_left),
        .servo_right (servo_right),
        .frame_start (frame_start),
        .failsafe    (failsafe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic push(input int l, input int r, input int fs);
        exp_t e;
        e.l_us = l; e.r_us = r; e.fs = fs;
        sb.push_back(e);
    endtask

    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < FRAME * CLKS + 20) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) chk("frame_start_timeout", 0, 1);
    endtask

    task automatic send(input int l, input int r);
        @(negedge clk);
        cif.wheel_left  = 8'(l);
        cif.wheel_right = 8'(r);
        cif.cmd_valid   = 1'b1;
        @(negedge clk);
        cif.cmd_valid   = 1'b0;
    endtask

    // Monitor: measures each frame's pulse lengths and failsafe level, then
    // checks them against the scoreboard when the next frame starts.
    initial begin
        int hl, hr, fs_last, fidx;
        bit started;
        exp_t e;
        hl = 0; hr = 0; fs_last = 0; fidx = 0; started = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (frame_start) begin
                    if (started) begin
                        fidx++;
                        if (sb.size() == 0) begin
                            chk($sformatf("f%0d_sb_empty", fidx), 0, 1);
                        end else begin
                            e = sb.pop_front();
                            chk($sformatf("f%0d_left_clks", fidx), hl, e.l_us * CLKS);
                            chk($sformatf("f%0d_right_clks", fidx), hr, e.r_us * CLKS);
                            chk($sformatf("f%0d_failsafe", fidx), fs_last, e.fs);
                        end
                    end
                    started = 1'b1;
                    hl = 0; hr = 0;
                end else begin
                    if (servo_left)  hl++;
                    if (servo_right) hr++;
                    fs_last = int'(failsafe);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        cif.wheel_left  = '0;
        cif.wheel_right = '0;
        cif.cmd_valid   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_servo_left",  int'(servo_left),  0);
        chk("rst_servo_right", int'(servo_right), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_failsafe",    int'(failsafe),    0);
        chk("rst_cmd_ready",   int'(cif.cmd_ready), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", int'(cif.cmd_ready), 1);
        chk("no_early_frame",  int'(frame_start), 0);
        @(posedge clk); #1;
        chk("first_frame_start", int'(frame_start), 1);

        wait_frame(); push(1500, 1500, 0);              // F1 neutral
        repeat (300) @(negedge clk);
        send(50, 50);
        wait_frame(); push(1700, 1300, 0);              // F2 applied
        wait_frame();                                   // F3 same-cycle accept
        cif.wheel_left  = 8'sd0 - 8'sd128;
        cif.wheel_right = 8'sd127;
        cif.cmd_valid   = 1'b1;
        push(1000, 1000, 0);
        @(negedge clk);
        cif.cmd_valid   = 1'b0;
        wait_frame(); push(1000, 1000, 0);              // F4 wd 1
        wait_frame(); push(1000, 1000, 0);              // F5 wd 2
        wait_frame(); push(1500, 1500, 1);              // F6 failsafe
        wait_frame(); push(1500, 1500, 1);              // F7 still failsafe
        repeat (300) @(negedge clk);
        send(50, 50);
        wait_frame(); push(1700, 1300, 0);              // F8 back to run
        repeat (800 * CLKS) @(negedge clk);
        enable = 1'b0;
        wait_frame(); push(0, 0, 0);                    // F9 idle
        repeat (300) @(negedge clk);
        enable = 1'b1;
        wait_frame(); push(1700, 1300, 0);              // F10 resumed
        wait_frame(); push(1700, 1300, 0);              // F11
        wait_frame();                                   // F12 closes F11
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_pulse_left",  int'(servo_left),  1);
        chk("mid_pulse_right", int'(servo_right), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_left",  int'(servo_left),  0);
        chk("async_rst_right", int'(servo_right), 0);
        chk("async_rst_ready", int'(cif.cmd_ready), 0);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
